lift_sched_ctrl: RTL and testbench

//  Parametrised N-floor elevator controller: latches floor calls into a pending mask and serves

---
 rtl/lift_pkg.sv | 37 +++
 rtl/lift_timer.sv | 38 +++
 rtl/lift_sched_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lift_sched_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types and helpers for the SCAN elevator controller: state encoding,
// direction constants and above/below floor masks.
package lift_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MOVE  = 2'd1,
      ST_DOORS = 2'd2
   } state_e;

   localparam logic DIR_DOWN   = 1'b0;
   localparam logic DIR_UP     = 1'b1;
   localparam int   MAX_FLOORS = 16;

   // Floors strictly above f; callers truncate to their own floor count.
   function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [3:0] f);
      logic [MAX_FLOORS-1:0] m;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         m[i] = (i > int'(f));
      end
      return m;
   endfunction

   function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [3:0] f);
      logic [MAX_FLOORS-1:0] m;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         m[i] = (i < int'(f));
      end
      return m;
   endfunction

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter that stops at zero; used for travel, door and idle timing.
module lift_timer
   import lift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/lift_sched_ctrl.sv
// N-floor SCAN elevator controller with travel timing and re-openable door dwell.
// Optional idle return to HOME_FLOOR is built when LIFT_HOME_RETURN_EN is defined.
module lift_sched_ctrl
   import lift_pkg::*;
#(
   parameter int N_FLOORS   = 8,
   parameter int FLOOR_W    = $clog2(N_FLOORS),
   parameter int TRAVEL_CYC = 4,
   parameter int DOOR_CYC   = 4,
   parameter int HOME_FLOOR = 0,
   parameter int IDLE_CYC   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_FLOORS-1:0] call_req,
   output logic [FLOOR_W-1:0]  floor,
   output logic [N_FLOORS-1:0] floor_led,
   output logic                dir_up,
   output logic                moving,
   output logic                door_open,
   output logic [N_FLOORS-1:0] pending
);

   localparam int TRAVEL_W = cnt_w(TRAVEL_CYC);
   localparam int DOOR_W   = cnt_w(DOOR_CYC);
   localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYC - 1);
   localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYC - 1);

   state_e               state_q, state_d;
   logic [FLOOR_W-1:0]   floor_q, floor_d;
   logic                 dir_up_q, dir_up_d;
   logic [N_FLOORS-1:0]  pending_q, pending_d;
   logic [N_FLOORS-1:0]  floor_led_q, floor_led_d;
   logic                 moving_q, moving_d;
   logic                 door_open_q, door_open_d;

   logic [N_FLOORS-1:0]  req, here, above, below, ahead, behind;
   logic [N_FLOORS-1:0]  step_oh, clear_mask, latch_mask, home_set;
   logic [FLOOR_W-1:0]   floor_step;
   logic                 at_end, reopen;
   logic                 travel_load, travel_zero, door_load, door_zero;

   // Decisions see this cycle's buttons too, so a call acts without waiting a cycle.
   assign req    = pending_q | call_req;
   assign here   = N_FLOORS'(1) << floor_q;
   assign above  = N_FLOORS'(above_mask(4'(floor_q)));
   assign below  = N_FLOORS'(below_mask(4'(floor_q)));
   assign ahead  = req & ((dir_up_q == DIR_UP) ? above : below);
   assign behind = req & ((dir_up_q == DIR_UP) ? below : above);

   assign at_end     = (dir_up_q == DIR_UP) ? (floor_q == FLOOR_W'(N_FLOORS - 1))
                                            : (floor_q == '0);
   assign floor_step = (dir_up_q == DIR_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
   assign step_oh    = N_FLOORS'(1) << floor_step;

   // With doors open, the current-floor button only holds the doors; it is never latched.
   assign reopen     = (state_q == ST_DOORS) && |(call_req & here);
   assign latch_mask = (state_q == ST_DOORS) ? ~here : '1;

`ifdef LIFT_HOME_RETURN_EN
   localparam int IDLE_W = cnt_w(IDLE_CYC);
   logic idle_qual, idle_zero;

   assign idle_qual = (state_q == ST_IDLE) && (pending_q == '0) && (call_req == '0)
                      && (floor_q != FLOOR_W'(HOME_FLOOR));

   lift_timer #(.WIDTH(IDLE_W)) u_idle_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (!idle_qual),
      .value (IDLE_W'(IDLE_CYC - 1)),
      .en    (idle_qual),
      .zero  (idle_zero)
   );

   assign home_set = (idle_qual && idle_zero) ? (N_FLOORS'(1) << HOME_FLOOR) : '0;
`else
   assign home_set = '0;
`endif

   lift_timer #(.WIDTH(TRAVEL_W)) u_travel_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (travel_load),
      .value (TRAVEL_LOAD),
      .en    (state_q == ST_MOVE),
      .zero  (travel_zero)
   );

   lift_timer #(.WIDTH(DOOR_W)) u_door_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (door_load),
      .value (DOOR_LOAD),
      .en    (state_q == ST_DOORS),
      .zero  (door_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         floor_q     <= '0;
         dir_up_q    <= DIR_UP;
         pending_q   <= '0;
         floor_led_q <= N_FLOORS'(1);
         moving_q    <= 1'b0;
         door_open_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         floor_q     <= floor_d;
         dir_up_q    <= dir_up_d;
         pending_q   <= pending_d;
         floor_led_q <= floor_led_d;
         moving_q    <= moving_d;
         door_open_q <= door_open_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      floor_d     = floor_q;
      dir_up_d    = dir_up_q;
      clear_mask  = '0;
      travel_load = 1'b0;
      door_load   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|(req & here)) begin
               state_d    = ST_DOORS;
               clear_mask = here;
               door_load  = 1'b1;
            end else if (|ahead) begin
               state_d     = ST_MOVE;
               travel_load = 1'b1;
            end else if (|behind) begin
               state_d     = ST_MOVE;
               dir_up_d    = ~dir_up_q;
               travel_load = 1'b1;
            end
         end
         ST_MOVE: begin
            if (travel_zero && !at_end) begin
               floor_d = floor_step;
               if (|(req & step_oh)) begin
                  state_d    = ST_DOORS;
                  clear_mask = step_oh;
                  door_load  = 1'b1;
               end else begin
                  travel_load = 1'b1;
               end
            end
         end
         ST_DOORS: begin
            if (reopen) begin
               door_load = 1'b1;
            end else if (door_zero) begin
               if (|ahead) begin
                  state_d     = ST_MOVE;
                  travel_load = 1'b1;
               end else if (|behind) begin
                  state_d     = ST_MOVE;
                  dir_up_d    = ~dir_up_q;
                  travel_load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A served floor's clear wins over a same-cycle call for it.
      pending_d = (pending_q | (call_req & latch_mask) | home_set) & ~clear_mask;
   end

   always_comb begin
      moving_d    = (state_d == ST_MOVE);
      door_open_d = (state_d == ST_DOORS);
      floor_led_d = N_FLOORS'(1) << floor_d;
   end

   assign floor     = floor_q;
   assign floor_led = floor_led_q;
   assign dir_up    = dir_up_q;
   assign moving    = moving_q;
   assign door_open = door_open_q;
   assign pending   = pending_q;

   // SCAN only moves toward a pending call, so an end floor can never be overrun.
   a_no_overrun: assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_MOVE) |-> !at_end);

   a_config: assert property (@(posedge clk)
      (N_FLOORS >= 2) && (N_FLOORS <= MAX_FLOORS) && (TRAVEL_CYC >= 1) && (DOOR_CYC >= 1)
      && (HOME_FLOOR >= 0) && (HOME_FLOOR < N_FLOORS) && (IDLE_CYC >= 1));

endmodule

// File: tb/tb_lift_sched_ctrl.sv
// Self-checking bench for lift_sched_ctrl: vector table, directed corner sequences and
// random calls compared every cycle against a floor-by-floor behavioural model.
module tb_lift_sched_ctrl;

   localparam int NF     = 8;
   localparam int FW     = 3;
   localparam int TRAVEL = 4;
   localparam int DOOR   = 4;
   localparam int HOME   = 0;
   localparam int IDLE_N = 16;

   localparam logic [31:0] RESET_VEC = 32'({3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00});

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NF-1:0] call_req = '0;
   logic [FW-1:0] floor;
   logic [NF-1:0] floor_led;
   logic          dir_up, moving, door_open;
   logic [NF-1:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   lift_sched_ctrl #(
      .N_FLOORS   (NF),
      .FLOOR_W    (FW),
      .TRAVEL_CYC (TRAVEL),
      .DOOR_CYC   (DOOR),
      .HOME_FLOOR (HOME),
      .IDLE_CYC   (IDLE_N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .call_req  (call_req),
      .floor     (floor),
      .floor_led (floor_led),
      .dir_up    (dir_up),
      .moving    (moving),
      .door_open (door_open),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_MOVE, M_DOORS} mode_t;
   mode_t         m_mode;
   int            m_floor;
   bit            m_up;
   logic [NF-1:0] m_pend;
   int            m_t;
`ifdef LIFT_HOME_RETURN_EN
   int            m_idle;
`endif

   function automatic bit any_side(input logic [NF-1:0] r, input int f, input bit up);
      for (int i = 0; i < NF; i++) begin
         if (r[i] && (up ? (i > f) : (i < f))) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_floor = 0;
      m_up    = 1'b1;
      m_pend  = '0;
      m_t     = 0;
`ifdef LIFT_HOME_RETURN_EN
      m_idle  = 0;
`endif
   endtask

   // Pick a new heading from the outstanding calls, or rest.
   task automatic model_depart(input logic [NF-1:0] req);
      m_t = 0;
      if (any_side(req, m_floor, m_up)) begin
         m_mode = M_MOVE;
      end else if (any_side(req, m_floor, !m_up)) begin
         m_up   = !m_up;
         m_mode = M_MOVE;
      end else begin
         m_mode = M_IDLE;
      end
   endtask

   task automatic model_step(input logic [NF-1:0] call);
      logic [NF-1:0] req, nxt;
      req = m_pend | call;
      nxt = m_pend | call;
`ifdef LIFT_HOME_RETURN_EN
      if (m_mode == M_IDLE && m_pend == '0 && call == '0 && m_floor != HOME) begin
         m_idle++;
         if (m_idle == IDLE_N) begin
            nxt[HOME] = 1'b1;
            m_idle    = 0;
         end
      end else begin
         m_idle = 0;
      end
`endif
      case (m_mode)
         M_IDLE: begin
            if (req[m_floor]) begin
               m_mode       = M_DOORS;
               m_t          = 0;
               nxt[m_floor] = 1'b0;
            end else begin
               model_depart(req);
            end
         end
         M_MOVE: begin
            m_t++;
            if (m_t == TRAVEL) begin
               m_floor = m_up ? m_floor + 1 : m_floor - 1;
               m_t     = 0;
               if (req[m_floor]) begin
                  m_mode       = M_DOORS;
                  nxt[m_floor] = 1'b0;
               end
            end
         end
         M_DOORS: begin
            nxt[m_floor] = m_pend[m_floor];
            if (call[m_floor]) begin
               m_t = 0;
            end else begin
               m_t++;
               if (m_t == DOOR) model_depart(req);
            end
         end
         default: m_mode = M_IDLE;
      endcase
      m_pend = nxt;
   endtask

   function automatic logic [31:0] model_vec();
      logic [NF-1:0] led;
      led = NF'(1) << m_floor;
      return 32'({FW'(m_floor), led, m_up, (m_mode == M_MOVE), (m_mode == M_DOORS), m_pend});
   endfunction

   function automatic logic [31:0] dut_vec();
      return 32'({floor, floor_led, dir_up, moving, door_open, pending});
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic [NF-1:0] c);
      call_req = c;
      model_step(c);
      @(posedge clk);
      #1;
      call_req = '0;
      check("model", dut_vec(), model_vec());
   endtask

   task automatic do_reset(input logic [NF-1:0] c);
      rst      = 1'b1;
      call_req = c;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      call_req = '0;
      model_reset();
      check("reset", dut_vec(), RESET_VEC);
   endtask

   task automatic run_until_floor(input int f, input int max_cyc);
      int n;
      n = 0;
      while (int'(floor) != f && n < max_cyc) begin
         cycle('0);
         n++;
      end
      check("reach_floor", 32'(floor), 32'(f));
   endtask

   task automatic run_until_door(input int max_cyc);
      int n;
      n = 0;
      while (!door_open && n < max_cyc) begin
         cycle('0);
         n++;
      end
      check("reach_door", 32'(door_open), 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [NF-1:0] call;
      logic [FW-1:0] f_floor;
      logic          f_dir;
      logic          f_moving;
      logic          f_door;
      logic [NF-1:0] f_pend;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int n;
      bit seen_move, prev;
      int dfl[$];
      bit ddir[$];
      logic [NF-1:0] c;
      int r;
      logic [NF-1:0] led;

      // Same-floor call from reset, a latched call during doors, then one floor of travel.
      tbl[0] = '{8'h01, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[1] = '{8'h02, 3'd0, 1'b1, 1'b0, 1'b1, 8'h02};
      tbl[2] = '{8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'h02};
      tbl[3] = '{8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'h02};
      tbl[4] = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h02};
      tbl[5] = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h02};
      tbl[6] = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h02};
      tbl[7] = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h02};
      tbl[8] = '{8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 8'h00};

      do_reset('0);
      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].call);
         led = NF'(1) << tbl[i].f_floor;
         check("table", dut_vec(),
               32'({tbl[i].f_floor, led, tbl[i].f_dir, tbl[i].f_moving, tbl[i].f_door,
                    tbl[i].f_pend}));
      end

      // Single call to floor 5: one floor per TRAVEL cycles, DOOR cycles of doors, idle.
      do_reset('0);
      cycle(8'h20);
      check("t1_move_next", 32'(moving), 1);
      for (int k = 1; k <= 5 * TRAVEL; k++) begin
         cycle('0);
         if (k % TRAVEL == 0) check("t1_floor", 32'(floor), 32'(k / TRAVEL));
      end
      check("t1_door_at_5", 32'(door_open), 1);
      n = 0;
      for (int k = 0; k < 20 && door_open; k++) begin
         n++;
         cycle('0);
      end
      check("t1_door_cycles", 32'(n), 4);
      check("t1_idle", 32'({moving, door_open, pending}), 32'(0));

      // Call for the current floor while idle opens the doors without moving.
      cycle(8'h20);
      check("t5_door_next", 32'({moving, door_open}), 32'(1));
      seen_move = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle('0);
         seen_move |= moving;
      end
      check("t5_never_moved", 32'(seen_move), 0);

`ifdef LIFT_HOME_RETURN_EN
      for (int k = 0; k < IDLE_N; k++) cycle('0);
      check("t6_home_pending", 32'(pending), 32'(8'h01));
      cycle('0);
      check("t6_move_down", 32'({moving, dir_up}), 32'(2'b10));
      run_until_door(100);
      check("t6_home_floor", 32'(floor), 0);
`else
      for (int k = 0; k < 40; k++) cycle('0);
      check("t6_stays", 32'({floor, moving, pending}), 32'({3'd5, 1'b0, 8'h00}));
`endif

      // Same-floor call on door cycle 2 holds the doors for a full dwell.
      do_reset('0);
      cycle(8'h08);
      run_until_door(60);
      check("t3_floor", 32'(floor), 3);
      cycle('0);
      cycle(8'h08);
      check("t3_not_latched", 32'(pending[3]), 0);
      n = 0;
      for (int k = 0; k < 20 && door_open; k++) begin
         n++;
         cycle('0);
      end
      check("t3_door_held", 32'(n), 4);

      // Moving up past floor 2, calls at 0 and 6: serve 6 first, reverse, then 0.
      do_reset('0);
      cycle(8'h40);
      run_until_floor(2, 40);
      cycle(8'h41);
      prev = door_open;
      for (int k = 0; k < 300; k++) begin
         cycle('0);
         if (door_open && !prev) begin
            dfl.push_back(int'(floor));
            ddir.push_back(dir_up);
         end
         prev = door_open;
         if (!moving && !door_open && pending == '0) break;
      end
      check("t2_stops", 32'(dfl.size()), 2);
      if (dfl.size() >= 2) begin
         check("t2_first_stop", 32'(dfl[0]), 6);
         check("t2_second_stop", 32'(dfl[1]), 0);
         check("t2_dir_down", 32'(ddir[1]), 0);
      end

      // Reset between floors 4 and 5 returns everything to reset values.
      do_reset('0);
      cycle(8'h20);
      run_until_floor(4, 40);
      cycle('0);
      cycle('0);
      check("t4_mid_move", 32'(moving), 1);
      do_reset(8'h02);

      // Random calls against the model.
      for (int k = 0; k < 3000; k++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) c = NF'(1) << $urandom_range(0, NF - 1);
         else if (r == 1) c = NF'($urandom) & NF'($urandom);
         else c = '0;
         cycle(c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
